unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified memory between the processor's instruction-fetch port and data port. One transaction is outstanding at a time. Round-robin arbitration on conflict. Tracks read latency so read data returns to the port that requested it. Drives a `stall` to the controller whenever either port is waiting, which lets the processor core run against a shared memory instead of split instruction and data memories.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 2, cycles from command to read data; legal range 1..15

Ports:
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `i_req` in 1: instruction read request
- `i_addr` in AW: instruction address
- `i_gnt` out 1: instruction command accepted this cycle
- `i_rvalid` out 1: instruction read data valid
- `i_rdata` out DW: instruction read data
- `d_req` in 1: data request
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in AW: data address
- `d_wdata` in DW: write data
- `d_gnt` out 1: data command accepted this cycle
- `d_rvalid` out 1: data read data valid
- `d_rdata` out DW: data read data
- `m_en` out 1: memory command strobe
- `m_we` out 1: memory write enable
- `m_addr` out AW: memory address
- `m_wdata` out DW: memory write data
- `m_rdata` in DW: memory read data, valid MEM_LAT cycles after an `m_en` read
- `stall` out 1: core must hold state this cycle

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - BUSY: read outstanding; latency counter `cnt` runs MEM_LAT-1 down to 0.
- IDLE with any request pending:
  - Winner gets `gnt` combinationally in the same cycle.
  - `m_en`=1 in that cycle, with `m_addr`/`m_we`/`m_wdata` muxed from the winner. The instruction port always presents `m_we`=0.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not granted last wins.
  - `last` pointer resets to "instruction", so data wins the first conflict.
  - `last` updates on every grant.
- Write grant: the transaction completes in the grant cycle. The FSM stays in IDLE, so a new grant is possible the next cycle. No `rvalid` is produced.
- Read grant:
  - FSM enters BUSY. `cnt` loads MEM_LAT-1 and a `owner` bit records the winning port.
  - While in BUSY, no grants and `m_en`=0.
- Read return, when BUSY and `cnt`==0 (MEM_LAT cycles after the grant):
  - `owner`'s `rvalid`=1 and its `rdata`=`m_rdata`.
  - FSM returns to IDLE and may issue a new grant in the same cycle (back-to-back).
- `rdata` on a port is 0 whenever that port's `rvalid`=0.
- `stall`=1 when either:
  - a port has `req`=1 and `gnt`=0, or
  - a granted read has not yet returned (BUSY, excluding the return cycle).
- Requester rules:
  - Hold `req`, `addr`, `we` and `wdata` stable until `gnt`.
  - After `gnt` a port may drop or change its request.
  - A port must not re-request before its own `rvalid` arrives. Such a request is held ungranted; it is not an error.
- Reset, mid-operation included:
  - FSM goes to IDLE, `cnt`=0, `last`=instruction, `owner`=0.
  - All outputs are 0.
  - Any in-flight read is abandoned; no `rvalid` is ever produced for it.

## Timing
- Grant latency: 0 cycles when IDLE. Otherwise the port waits until the return cycle of the current read.
- Read latency: `rvalid` is high exactly in cycle C+MEM_LAT, where C is the grant cycle.
- Write occupancy: 1 cycle.
- Sustained throughput:
  - Reads: one per MEM_LAT cycles.
  - Writes: one per cycle.
- All outputs are combinational from state plus requests. The only registers are the FSM state, `cnt`, `last` and `owner`.
- `cnt` width is 4 bits. There is no wrap-around: `cnt` is loaded only from IDLE and stops at 0.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 with `i_req`=`d_req`=1.
  - Response: every output is 0.
  - Stimulus: release `rst`.
  - Response: `d_gnt`=1 in the first cycle.
- Single fetch, MEM_LAT=2:
  - Stimulus: `i_req`, `i_addr`=0x40 at cycle 0; memory returns 0x12345678.
  - Response: `i_gnt`/`m_en` at cycle 0 with `m_addr`=0x40; `stall`=1 in cycles 0–1; cycle 2 has `i_rvalid`=1, `i_rdata`=0x12345678 and `stall`=0.
- Conflict:
  - Stimulus: both ports read continuously from reset.
  - Response: grants alternate D at cycle 0, I at cycle 2, D at cycle 4, I at cycle 6. Each `rvalid` appears on the matching port only, 2 cycles after its grant.
- Write then fetch:
  - Stimulus: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF at cycle 0, with `i_req` also high.
  - Response: cycle 0 has `m_we`=1 and `d_gnt`=1. Cycle 1 has `i_gnt`=1. No `d_rvalid` ever.
- Reset mid-read:
  - Stimulus: assert `rst` in cycle 1 of a data read.
  - Response: no `d_rvalid` at any later cycle. After release, a new read completes normally.
- MEM_LAT=1:
  - Stimulus: back-to-back instruction reads.
  - Response: a grant every cycle, and `i_rvalid` one cycle after each grant.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between an instruction
// fetch port and a data port. One read may be outstanding at a time. Conflicts
// are resolved round-robin, and read data is steered back to the port that
// issued the read. A stall is raised while either port is waiting.
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_last, w_last_nxt;     // port granted last: 0 = instruction, 1 = data
    logic       r_owner, w_owner_nxt;   // port owning the outstanding read: 0 = instruction, 1 = data

    logic w_ret;        // outstanding read returns this cycle
    logic w_free;       // a new command may be issued this cycle
    logic w_gi;
    logic w_gd;
    logic w_rd_gnt;     // the command issued this cycle is a read

    // Arbitration, memory command mux, read return steering, next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;

        w_ret    = (r_state == BUSY) && (r_cnt == 4'd0);
        // Every output is forced low while reset is held, even with requests pending.
        w_free   = rst && ((r_state == IDLE) || w_ret);
        w_gi     = w_free && i_req && (!d_req || r_last);
        w_gd     = w_free && d_req && (!i_req || !r_last);
        w_rd_gnt = w_gi || (w_gd && !d_we);

        i_gnt    = w_gi;
        d_gnt    = w_gd;
        m_en     = w_gi || w_gd;
        m_we     = w_gd && d_we;
        m_addr   = '0;
        m_wdata  = '0;
        if (w_gd) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (w_gi) begin
            m_addr  = i_addr;
        end

        i_rvalid = rst && w_ret && !r_owner;
        d_rvalid = rst && w_ret && r_owner;
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;

        // A read counts as pending from its grant cycle until (not including) its return cycle.
        stall = rst && ((i_req && !w_gi) || (d_req && !w_gd) || w_rd_gnt
                        || ((r_state == BUSY) && !w_ret));

        if (r_state == BUSY) begin
            if (r_cnt != 4'd0) begin
                w_cnt_nxt = r_cnt - 4'd1;
            end else begin
                w_state_nxt = IDLE;
            end
        end
        // A grant in the return cycle overrides the return-to-IDLE above (back-to-back reads).
        if (w_gi || w_gd) begin
            w_last_nxt = w_gd;
            if (w_rd_gnt) begin
                w_state_nxt = BUSY;
                w_cnt_nxt   = 4'(MEM_LAT - 1);
                w_owner_nxt = w_gd;
            end
        end
    end

    // State, latency counter, round-robin pointer and read owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed, table-driven checks of the arbiter with
// MEM_LAT=2, plus a hand-written back-to-back read sequence with MEM_LAT=1.
module tb_unified_mem_arbiter;

    typedef struct packed {
        logic        ig;
        logic        iv;
        logic [31:0] ird;
        logic        dg;
        logic        dv;
        logic [31:0] drd;
        logic        men;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        st;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [31:0] mr;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=2 instance
    logic        rst = 1'b0, i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, stall;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    // MEM_LAT=1 instance
    logic        rst1 = 1'b0, i_req1 = 1'b0;
    logic [31:0] i_addr1 = '0, m_rdata1 = '0;
    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1, stall1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .stall(stall)
    );

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
        .stall(stall1)
    );

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [31:0] mr,
                       input logic ig, input logic iv, input logic [31:0] ird,
                       input logic dg, input logic dv, input logic [31:0] drd,
                       input logic men, input logic mwe, input logic [31:0] maddr,
                       input logic [31:0] mwd, input logic st);
        vec_t v;
        v.name = name; v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
        v.da = da; v.dd = dd; v.mr = mr;
        v.exp = '{ig: ig, iv: iv, ird: ird, dg: dg, dv: dv, drd: drd,
                  men: men, mwe: mwe, maddr: maddr, mwd: mwd, st: st};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t act, input out_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        out_t act;

        //  name            rst ir ia        dr dw da          dd            mr
        //                  ig iv ird          dg dv drd          men mwe maddr       mwd           st
        add("rst_hold0",    0, 1, 32'h40,  1, 0, 32'h80,  32'h0,        32'hAA,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        0);
        add("rst_hold1",    0, 1, 32'h40,  1, 0, 32'h80,  32'h0,        32'hAA,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        0);
        add("cf_c0_dgnt",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'hBB,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 0, 32'h80,    32'h0,        1);
        add("cf_c1_busy",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'hCC,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("cf_c2_dret",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'h0D0D0001,
                            1, 0, 32'h0,       0, 1, 32'h0D0D0001, 1, 0, 32'h10,   32'h0,        1);
        add("cf_c3_busy",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'hFFFF,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("cf_c4_iret",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'h11110002,
                            0, 1, 32'h11110002, 1, 0, 32'h0,      1, 0, 32'h80,    32'h0,        1);
        add("cf_c5_busy",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'h5,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("cf_c6_dret",   1, 1, 32'h10,  1, 0, 32'h80,  32'h0,        32'h0D0D0003,
                            1, 0, 32'h0,       0, 1, 32'h0D0D0003, 1, 0, 32'h10,   32'h0,        1);
        add("cf_c7_noreq",  1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h7,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("cf_c8_iret",   1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h11110004,
                            0, 1, 32'h11110004, 0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        0);
        add("wr_c0",        1, 1, 32'h40,  1, 1, 32'h100, 32'hDEADBEEF, 32'h9,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 1, 32'h100,   32'hDEADBEEF, 1);
        add("wr_c1_fetch",  1, 1, 32'h40,  0, 0, 32'h0,   32'h0,        32'hA,
                            1, 0, 32'h0,       0, 0, 32'h0,       1, 0, 32'h40,    32'h0,        1);
        add("fetch_c1",     1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'hB,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("fetch_c2",     1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h12345678,
                            0, 1, 32'h12345678, 0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        0);
        add("wr_b2b_0",     1, 0, 32'h0,   1, 1, 32'h104, 32'h1,        32'h0,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 1, 32'h104,   32'h1,        0);
        add("wr_b2b_1",     1, 0, 32'h0,   1, 1, 32'h108, 32'h2,        32'h0,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 1, 32'h108,   32'h2,        0);
        add("rmid_c0",      1, 0, 32'h0,   1, 0, 32'h200, 32'h0,        32'h0,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 0, 32'h200,   32'h0,        1);
        add("rmid_rst",     0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h0,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        0);
        add("rmid_c2",      1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h55,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        0);
        add("rmid_c3",      1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h66,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        0);
        add("rnew_c0",      1, 1, 32'h44,  1, 0, 32'h204, 32'h0,        32'h0,
                            0, 0, 32'h0,       1, 0, 32'h0,       1, 0, 32'h204,   32'h0,        1);
        add("rnew_c1",      1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h0,
                            0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,     32'h0,        1);
        add("rnew_c2",      1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        32'hCAFEF00D,
                            0, 0, 32'h0,       0, 1, 32'hCAFEF00D, 0, 0, 32'h0,    32'h0,        0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            rst = vecs[k].rst; i_req = vecs[k].ir; i_addr = vecs[k].ia;
            d_req = vecs[k].dr; d_we = vecs[k].dw; d_addr = vecs[k].da;
            d_wdata = vecs[k].dd; m_rdata = vecs[k].mr;
            @(negedge clk);
            act = '{ig: i_gnt, iv: i_rvalid, ird: i_rdata, dg: d_gnt, dv: d_rvalid, drd: d_rdata,
                    men: m_en, mwe: m_we, maddr: m_addr, mwd: m_wdata, st: stall};
            check(vecs[k].name, act, vecs[k].exp);
        end

        // MEM_LAT=1: back-to-back fetches, a grant every cycle, data one cycle later
        @(posedge clk);
        #1 rst1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            i_req1   = (k < 5);
            i_addr1  = 32'h200 + 32'(4 * k);
            m_rdata1 = 32'h1000 + 32'(k);
            @(negedge clk);
            act = '{ig: i_gnt1, iv: i_rvalid1, ird: i_rdata1, dg: d_gnt1, dv: d_rvalid1, drd: d_rdata1,
                    men: m_en1, mwe: m_we1, maddr: m_addr1, mwd: m_wdata1, st: stall1};
            check($sformatf("lat1_c%0d", k), act,
                  '{ig: (k < 5), iv: (k > 0), ird: (k > 0) ? 32'h1000 + 32'(k) : 32'h0,
                    dg: 1'b0, dv: 1'b0, drd: 32'h0,
                    men: (k < 5), mwe: 1'b0, maddr: (k < 5) ? 32'h200 + 32'(4 * k) : 32'h0,
                    mwd: 32'h0, st: (k < 5)});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
